// File: rtl/spike_rate_decoder.sv
// Receive-side spike decoder: turns a 1-bit spike train into a per-window spike
// count and the latest inter-spike interval, delivered over valid/ready.
//
// state    | meaning
// ST_EMPTY | no unconsumed result, out_valid=0
// ST_FULL  | result registers hold an unconsumed result, out_valid=1
module spike_rate_decoder #(
   parameter int WINDOW_CYCLES = 256,
   parameter int COUNT_W       = 8,
   parameter int ISI_W         = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               spike_in,
   output logic [COUNT_W-1:0] rate_out,
   output logic [ISI_W-1:0]   isi_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               overrun
);

   localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
   localparam logic [ISI_W-1:0]   ISI_MAX  = '1;

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   state_t             state_q, state_d;
   logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
   logic [COUNT_W-1:0] spike_cnt_q, spike_cnt_d;
   logic [ISI_W-1:0]   isi_cnt_q, isi_cnt_d;
   logic               isi_seen_q, isi_seen_d;
   logic [ISI_W-1:0]   last_isi_q, last_isi_d;
   logic [COUNT_W-1:0] rate_q, rate_d;
   logic [ISI_W-1:0]   isi_q, isi_d;
   logic               overrun_q, overrun_d;

   logic               spike;
   logic               close;
   logic [COUNT_W-1:0] cnt_now;

   // Window, spike-count and ISI tracking; all frozen while enable=0.
   always_comb begin
      spike       = enable & spike_in;
      close       = 1'b0;
      cnt_now     = spike_cnt_q;
      win_cnt_d   = win_cnt_q;
      spike_cnt_d = spike_cnt_q;
      isi_cnt_d   = isi_cnt_q;
      isi_seen_d  = isi_seen_q;
      last_isi_d  = last_isi_q;

      if (spike && (spike_cnt_q != CNT_MAX)) begin
         cnt_now = spike_cnt_q + 1'b1;
      end

      if (enable) begin
         close       = (win_cnt_q == WIN_LAST);
         win_cnt_d   = close ? '0 : win_cnt_q + 1'b1;
         spike_cnt_d = close ? '0 : cnt_now;
         if (spike) begin
            if (isi_seen_q) begin
               last_isi_d = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + 1'b1;
            end
            isi_cnt_d  = '0;
            isi_seen_d = 1'b1;
         end else if (isi_cnt_q != ISI_MAX) begin
            isi_cnt_d = isi_cnt_q + 1'b1;
         end
      end
   end

   // Output FSM; the close-cycle spike is already folded into cnt_now/last_isi_d.
   always_comb begin
      state_d   = state_q;
      overrun_d = overrun_q;
      rate_d    = rate_q;
      isi_d     = isi_q;

      if (close) begin
         rate_d = cnt_now;
         isi_d  = last_isi_d;
      end

      unique case (state_q)
         ST_EMPTY: begin
            if (close) state_d = ST_FULL;
         end
         ST_FULL: begin
            if (close) begin
               if (!out_ready) overrun_d = 1'b1;
            end else if (out_ready) begin
               state_d   = ST_EMPTY;
               overrun_d = 1'b0;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_EMPTY;
         win_cnt_q   <= '0;
         spike_cnt_q <= '0;
         isi_cnt_q   <= '0;
         isi_seen_q  <= 1'b0;
         last_isi_q  <= '0;
         rate_q      <= '0;
         isi_q       <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_cnt_q   <= win_cnt_d;
         spike_cnt_q <= spike_cnt_d;
         isi_cnt_q   <= isi_cnt_d;
         isi_seen_q  <= isi_seen_d;
         last_isi_q  <= last_isi_d;
         rate_q      <= rate_d;
         isi_q       <= isi_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rate_out  = rate_q;
   assign isi_out   = isi_q;
   assign out_valid = (state_q == ST_FULL);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: 16-cycle window, 3-bit count and ISI
// so saturation is reachable within one window.
module tb_spike_rate_decoder;

   localparam int WIN = 16;
   localparam int CW  = 3;
   localparam int IW  = 3;

   typedef struct packed {
      logic [CW-1:0] rate;
      logic [IW-1:0] isi;
   } res_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b1;
   logic          spike_in = 1'b1;
   logic          out_ready = 1'b0;
   logic [CW-1:0] rate_out;
   logic [IW-1:0] isi_out;
   logic          out_valid;
   logic          overrun;

   res_t exp_q[$];
   res_t exp_r;
   int   checks = 0;
   int   failures = 0;

   spike_rate_decoder #(.WINDOW_CYCLES(WIN), .COUNT_W(CW), .ISI_W(IW)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .spike_in(spike_in),
      .rate_out(rate_out), .isi_out(isi_out), .out_valid(out_valid),
      .out_ready(out_ready), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic sp, input logic rd);
      enable    = en;
      spike_in  = sp;
      out_ready = rd;
      tick();
   endtask

   task automatic do_reset();
      tick();
      reset_n   = 1'b0;
      enable    = 1'b0;
      spike_in  = 1'b0;
      out_ready = 1'b0;
      #10;
      reset_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      enable = 1'b1; spike_in = 1'b1; out_ready = 1'b0; reset_n = 1'b0;
      repeat (3) tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%0b exp=0", overrun); end
      checks++; if (rate_out !== 3'd0) begin failures++; $display("FAIL rst_rate got=%0d exp=0", rate_out); end
      checks++; if (isi_out !== 3'd0) begin failures++; $display("FAIL rst_isi got=%0d exp=0", isi_out); end
      // Build up a pending result with overrun set, then reset mid-window.
      do_reset();
      for (int c = 0; c < 37; c++) drive(1'b1, (c % 5) == 0, 1'b0);
      checks++; if (out_valid !== 1'b1 || overrun !== 1'b1) begin failures++; $display("FAIL rst_pre got=%0b%0b exp=11", out_valid, overrun); end
      reset_n = 1'b0;
      #2;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%0b exp=0", out_valid); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_async_overrun got=%0b exp=0", overrun); end
      checks++; if (rate_out !== 3'd0) begin failures++; $display("FAIL rst_async_rate got=%0d exp=0", rate_out); end
      tick();
      reset_n = 1'b1;
      exp_q.delete();
      for (int c = 0; c < WIN + 1; c++) begin
         if (c == WIN - 1) exp_q.push_back('{rate: 3'd2, isi: 3'd4});
         drive(1'b1, (c == 3) || (c == 7), 1'b1);
         checks++; if (out_valid !== (c == WIN - 1)) begin failures++; $display("FAIL rst_window_valid c=%0d got=%0b exp=%0b", c, out_valid, (c == WIN - 1)); end
         if (c == WIN - 1 && exp_q.size() > 0) begin
            exp_r = exp_q.pop_front();
            checks++; if (rate_out !== exp_r.rate || isi_out !== exp_r.isi) begin failures++; $display("FAIL rst_window_data got=%0d/%0d exp=%0d/%0d", rate_out, isi_out, exp_r.rate, exp_r.isi); end
         end
      end
   endtask

   task automatic test_periodic();
      do_reset();
      for (int c = 0; c < 2 * WIN + 1; c++) begin
         if (c % WIN == WIN - 1) exp_q.push_back('{rate: 3'd4, isi: 3'd4});
         drive(1'b1, ((c % WIN) % 4) == 0, 1'b1);
         checks++; if (out_valid !== (c % WIN == WIN - 1)) begin failures++; $display("FAIL periodic_valid c=%0d got=%0b", c, out_valid); end
         if (c % WIN == WIN - 1) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL periodic_sb empty queue got=%0d/%0d", rate_out, isi_out); end
            else begin
               exp_r = exp_q.pop_front();
               if (rate_out !== exp_r.rate || isi_out !== exp_r.isi) begin failures++; $display("FAIL periodic_data c=%0d got=%0d/%0d exp=%0d/%0d", c, rate_out, isi_out, exp_r.rate, exp_r.isi); end
            end
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int c = 0; c < 2 * WIN; c++) begin
         if (c == WIN - 1) exp_q.push_back('{rate: 3'd7, isi: 3'd1});
         if (c == 2 * WIN - 1) exp_q.push_back('{rate: 3'd1, isi: 3'd7});
         drive(1'b1, (c < WIN) || (c == WIN + 9), 1'b1);
         if (c % WIN == WIN - 1) begin
            checks++;
            if (exp_q.size() == 0 || out_valid !== 1'b1) begin failures++; $display("FAIL sat_valid c=%0d got=%0b", c, out_valid); end
            else begin
               exp_r = exp_q.pop_front();
               if (rate_out !== exp_r.rate || isi_out !== exp_r.isi) begin failures++; $display("FAIL sat_data c=%0d got=%0d/%0d exp=%0d/%0d", c, rate_out, isi_out, exp_r.rate, exp_r.isi); end
            end
         end
      end
   endtask

   task automatic test_boundary();
      do_reset();
      for (int c = 0; c < 2 * WIN; c++) begin
         if (c == WIN - 1) exp_q.push_back('{rate: 3'd1, isi: 3'd0});
         if (c == 2 * WIN - 1) exp_q.push_back('{rate: 3'd1, isi: 3'd1});
         drive(1'b1, (c == WIN - 1) || (c == WIN), 1'b1);
         if (c % WIN == WIN - 1) begin
            checks++;
            if (exp_q.size() == 0 || out_valid !== 1'b1) begin failures++; $display("FAIL bound_valid c=%0d got=%0b", c, out_valid); end
            else begin
               exp_r = exp_q.pop_front();
               if (rate_out !== exp_r.rate || isi_out !== exp_r.isi) begin failures++; $display("FAIL bound_data c=%0d got=%0d/%0d exp=%0d/%0d", c, rate_out, isi_out, exp_r.rate, exp_r.isi); end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int c = 0; c < 2 * WIN; c++) begin
         if (c == WIN - 1) exp_q.push_back('{rate: 3'd3, isi: 3'd1});
         if (c == 2 * WIN - 1) begin
            exp_q.push_back('{rate: 3'd5, isi: 3'd1});
            void'(exp_q.pop_front());
         end
         drive(1'b1, (c < 3) || (c >= WIN && c < WIN + 5), 1'b0);
         if (c == WIN - 1) begin
            checks++; if (out_valid !== 1'b1 || rate_out !== 3'd3 || overrun !== 1'b0) begin failures++; $display("FAIL bp_first got=v%0b r%0d o%0b exp=v1 r3 o0", out_valid, rate_out, overrun); end
         end
      end
      exp_r = exp_q[0];
      checks++; if (out_valid !== 1'b1 || rate_out !== exp_r.rate || isi_out !== exp_r.isi) begin failures++; $display("FAIL bp_overwrite got=v%0b %0d/%0d exp=v1 %0d/%0d", out_valid, rate_out, isi_out, exp_r.rate, exp_r.isi); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun_set got=%0b exp=1", overrun); end
      drive(1'b1, 1'b0, 1'b1);
      void'(exp_q.pop_front());
      checks++; if (out_valid !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL bp_consume got=v%0b o%0b exp=v0 o0", out_valid, overrun); end
      for (int c = 2 * WIN + 1; c < 4 * WIN; c++) begin
         if (c == 3 * WIN - 1) exp_q.push_back('{rate: 3'd0, isi: 3'd1});
         if (c == 4 * WIN - 1) begin
            void'(exp_q.pop_front());
            exp_q.push_back('{rate: 3'd1, isi: 3'd7});
         end
         drive(1'b1, c == 50, c == 4 * WIN - 1);
         if (c == 3 * WIN - 1) begin
            checks++; if (out_valid !== 1'b1 || rate_out !== exp_q[0].rate || isi_out !== exp_q[0].isi) begin failures++; $display("FAIL bp_third got=v%0b %0d/%0d", out_valid, rate_out, isi_out); end
         end
      end
      exp_r = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL bp_close_ready got=v%0b o%0b exp=v1 o0", out_valid, overrun); end
      checks++; if (rate_out !== exp_r.rate || isi_out !== exp_r.isi) begin failures++; $display("FAIL bp_close_ready_data got=%0d/%0d exp=%0d/%0d", rate_out, isi_out, exp_r.rate, exp_r.isi); end
      drive(1'b1, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_final_consume got=%0b exp=0", out_valid); end
   endtask

   task automatic test_enable();
      logic gap;
      do_reset();
      for (int k = 0; k < WIN + 7; k++) begin
         gap = (k >= 6) && (k <= 10);
         if (k == WIN + 4) exp_q.push_back('{rate: 3'd2, isi: 3'd4});
         drive(!gap, gap || (k == 2) || (k == 11), 1'b1);
         checks++; if (out_valid !== (k == WIN + 4)) begin failures++; $display("FAIL en_valid k=%0d got=%0b exp=%0b", k, out_valid, (k == WIN + 4)); end
         if (k == WIN + 4) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL en_sb empty queue got=%0d/%0d", rate_out, isi_out); end
            else begin
               exp_r = exp_q.pop_front();
               if (rate_out !== exp_r.rate || isi_out !== exp_r.isi) begin failures++; $display("FAIL en_data got=%0d/%0d exp=%0d/%0d", rate_out, isi_out, exp_r.rate, exp_r.isi); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_saturation();
      test_boundary();
      test_backpressure();
      test_enable();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
